// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared opcodes, state encoding and width defaults for the execute sequencer
package sequencer_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int AW_DEFAULT = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational R-type ALU
// Ports: op (opcode), a/b (operands), y (result, mod 2^DW).
module alu32
    import sequencer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    // Shift amount uses only the low five bits; upper bits of b are ignored.
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = ($signed(a) < $signed(b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// rtl/regfile_alu_sequencer.sv - multi-cycle read/execute/writeback sequencer in front of a 32x32 register file
// Ports: clk/rst (sync active-high); instr_* valid/ready instruction intake;
// rf_* register-file enable, addresses and write data, rf_rdata1/2 registered read data;
// done (writeback pulse), result (last ALU result), busy (READ/EXEC/WB).
module regfile_alu_sequencer
    import sequencer_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_rt,
    input  logic [AW-1:0] instr_rd,
    output logic          rf_en,
    output logic [AW-1:0] rf_raddr1,
    output logic [AW-1:0] rf_raddr2,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rs_q, rs_d;
    logic [AW-1:0] rt_q, rt_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] alu_y;
    logic          accept;

    alu32 #(.DW(DW)) u_alu (
        .op (op_q),
        .a  (rf_rdata1),
        .b  (rf_rdata2),
        .y  (alu_y)
    );

    // Ready in WB lets the next instruction's READ follow the write edge directly,
    // which is what removes any read-after-write hazard.
    assign instr_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state_q != ST_IDLE);
    assign result      = result_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        result_d  = result_q;
        rf_en     = 1'b0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // The register file writes on every enabled edge; aim it at r0 with 0.
                rf_en     = 1'b1;
                rf_raddr1 = rs_q;
                rf_raddr2 = rt_q;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_y;
                state_d  = ST_WB;
            end
            ST_WB: begin
                rf_en    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = (rd_q == '0) ? '0 : result_q;
                done     = 1'b1;
                state_d  = accept ? ST_READ : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op_d = instr_op;
            rs_d = instr_rs;
            rt_d = instr_rt;
            rd_d = instr_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/regfile_alu_sequencer.md
Name: regfile_alu_sequencer

Overview:
- Multi-cycle R-type execute sequencer that sits directly in front of the team's 32x32 register file.
- Accepts one decoded instruction (op, rs, rt, rd) over a valid/ready handshake.
- Drives the register file's shared enable, read addresses and write port.
- Consumes the registered read data, computes a 32-bit ALU result and writes it back to rd.
- Register-file contract: reads are registered, with data valid one cycle after the enable edge. Every enabled edge also writes. Register r0 is hardwired-zero by convention.

Parameters:
- DW, 32, data width; must match the register file.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept this cycle.
- instr_op  in  3  ALU opcode.
- instr_rs  in  AW  source register 1.
- instr_rt  in  AW  source register 2.
- instr_rd  in  AW  destination register.
- rf_en  out  1  to register file ReadWriteEn.
- rf_raddr1  out  AW  to ReadAddress1.
- rf_raddr2  out  AW  to ReadAddress2.
- rf_waddr  out  AW  to WriteAddress.
- rf_wdata  out  DW  to WriteData.
- rf_rdata1  in  DW  from ReadData1.
- rf_rdata2  in  DW  from ReadData2.
- done  out  1  one-cycle pulse in the writeback cycle.
- result  out  DW  last computed result, held until next EXEC.
- busy  out  1  high in READ/EXEC/WB.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, instr_ready=1, busy=0, done=0, result=0, latched op/rs/rt/rd=0.
- Reset mid-operation: drops to IDLE at the next edge, with rf_en=0 in the following cycle. Writeback is aborted; no partial write.
- Accept: an instruction is accepted at an edge with instr_valid && instr_ready. op, rs, rt and rd are latched at that edge.
- States: IDLE, READ, EXEC, WB. All rf_* outputs decode combinationally from state and the latched fields only.
- IDLE:
  - rf_en=0, instr_ready=1.
  - Accept -> READ; otherwise stay in IDLE.
- READ:
  - rf_en=1, rf_raddr1=rs, rf_raddr2=rt.
  - rf_waddr=0, rf_wdata=0. The forced write is a harmless write of 0 into r0.
  - instr_ready=0. -> EXEC.
- EXEC:
  - rf_en=0. rf_rdata1/2 are now valid.
  - result <= ALU(op, rdata1, rdata2) at the edge. -> WB.
- WB:
  - rf_en=1, rf_waddr=rd, rf_wdata=result, done=1.
  - Read addresses are driven to 0; read data from this edge is ignored.
  - If rd==0, the sequencer drives rf_wdata=0 instead, so r0 stays zero.
  - instr_ready=1 in WB. Accept -> READ (back-to-back); otherwise -> IDLE.
- Throughput and latency:
  - Back-to-back: 3 cycles per instruction. Isolated: accept edge to writeback edge = 3 edges.
  - No RAW hazard exists: a WB write commits at the same edge that accepts the next instruction, so the next READ sees the updated value.
- ALU (all mod 2^32, overflow ignored):
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed a<b -> 32'd1, else 32'd0.
  - 6 SLL: a << b[4:0].
  - 7 SRL: logical a >> b[4:0]; b[31:5] ignored.
- instr_valid while not ready: ignored. The upstream must hold the instruction until a cycle with instr_ready=1.

Decomposition:
- Shared package sequencer_pkg:
  - Opcode constants OP_ADD..OP_SRL.
  - State encoding constants ST_IDLE=0, ST_READ=1, ST_EXEC=2, ST_WB=3.
  - DW/AW defaults.
- One combinational sub-module, alu32 (op, a, b -> y), reused by later pipeline work.
- The FSM, field latches and rf_* muxing stay in the top module.

Test Plan:
- Bench instantiates the sequencer with the existing register file and backdoor-preloads r1=5, r2=7, r3=32'hFFFF_FFFF, r0=0.
- ADD rs=1 rt=2 rd=4: rf_en high exactly in cycles 2 and 4 after accept. r4=12. done pulses once; result=12.
- SUB 1,2 -> r5: r5=32'hFFFF_FFFE. Then SLT rs=3 rt=1 rd=6: r6=1 (signed -1<5). Then SLT rs=1 rt=3 rd=7: r7=0.
- Back-to-back, with instr_valid held high for ADD 1,2->r8 then ADD 8,8->r9: second accept occurs in the first's WB cycle. r9=24 (no hazard); instructions are spaced 3 cycles apart.
- SLL rs=1 rt=2 rd=10: r10=640. SRL rs=3 rt=2 rd=11: r11=32'h01FF_FFFF. Then ADD 1,2 -> rd=0: r0 remains 0, done still pulses.
- Reset asserted in EXEC of OR 1,2->r12: r12 unchanged. Next cycle is IDLE with instr_ready=1, result=0, no rf_en.
- instr_valid toggled while busy: no extra accepts. Exactly one write per accepted instruction, counted by a write monitor.
